// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between memory micro-ops and a byte-enabled SRAM.
// Word-crossing accesses become two sequential word accesses.
module lsu_mem_ctrl #(
  parameter int MEM_SIZE       = 1024,
  parameter bit MISALIGN_SPLIT = 1'b1,
  parameter int WADDR_WIDTH    = $clog2(MEM_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [2:0]             req_funct3,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_wdata,
  output logic                   rsp_valid,
  output logic [31:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic                   mem_en,
  output logic                   mem_r,
  output logic                   mem_w,
  output logic [WADDR_WIDTH-1:0] mem_rAddr,
  output logic [WADDR_WIDTH-1:0] mem_wAddr,
  output logic [3:0]             mem_byteEn,
  output logic [31:0]            mem_in,
  input  logic [31:0]            mem_out
);

  typedef enum logic [2:0] {
    IDLE, ST0, ST1, LD0, LD1, LD2, RESP
  } state_t;

  state_t state, state_nx;

  logic                   we_q;
  logic [2:0]             f3_q;
  logic [1:0]             off_q;
  logic [WADDR_WIDTH-1:0] a_q;
  logic [31:0]            wdata_q;
  logic                   err_q;
  logic [31:0]            lo_q;
  logic [31:0]            hi_q;

  // byte mask over two adjacent words
  function automatic logic [7:0] mask8(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic [7:0] sz;
    case (f3[1:0])
      2'b00:   sz = 8'h01;
      2'b01:   sz = 8'h03;
      default: sz = 8'h0F;
    endcase
    return sz << off;
  endfunction

  logic [7:0] m_in;
  logic       err_in;
  logic       accept;

  assign m_in   = mask8(req_funct3, req_addr[1:0]);
  assign err_in = (req_funct3 == 3'b011)
               || (req_funct3[2:1] == 2'b11)
               || (req_we && req_funct3[2])
               || (!MISALIGN_SPLIT && (|m_in[7:4]));
  assign accept = req_valid && (state == IDLE);

  logic [7:0]             m_q;
  logic                   cross_q;
  logic [WADDR_WIDTH-1:0] a_nx;
  logic [63:0]            s64;
  logic [31:0]            x;
  logic [31:0]            ext;

  assign m_q     = mask8(f3_q, off_q);
  assign cross_q = |m_q[7:4];
  assign a_nx    = a_q + WADDR_WIDTH'(1);
  assign s64     = {32'b0, wdata_q} << {off_q, 3'b000};
  assign x       = 32'({hi_q, lo_q} >> {off_q, 3'b000});

  always_comb begin
    case (f3_q)
      3'b000:  ext = {{24{x[7]}}, x[7:0]};
      3'b001:  ext = {{16{x[15]}}, x[15:0]};
      3'b100:  ext = {24'b0, x[7:0]};
      3'b101:  ext = {16'b0, x[15:0]};
      default: ext = x;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b0;
      off_q   <= 2'b0;
      a_q     <= '0;
      wdata_q <= 32'b0;
      err_q   <= 1'b0;
      lo_q    <= 32'b0;
      hi_q    <= 32'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        off_q   <= req_addr[1:0];
        a_q     <= req_addr[WADDR_WIDTH+1:2];
        wdata_q <= req_wdata;
        err_q   <= err_in;
        lo_q    <= 32'b0;
        hi_q    <= 32'b0;
      end
      if (state == LD1) lo_q <= mem_out;
      if (state == LD2) hi_q <= mem_out;
    end
  end

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_err    = 1'b0;
    rsp_rdata  = 32'b0;
    mem_r      = 1'b0;
    mem_w      = 1'b0;
    mem_rAddr  = '0;
    mem_wAddr  = '0;
    mem_byteEn = 4'b0;
    mem_in     = 32'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (err_in)      state_nx = RESP;
          else if (req_we) state_nx = ST0;
          else             state_nx = LD0;
        end
      end
      ST0: begin
        mem_w      = 1'b1;
        mem_wAddr  = a_q;
        mem_byteEn = m_q[3:0];
        mem_in     = s64[31:0];
        state_nx   = cross_q ? ST1 : RESP;
      end
      ST1: begin
        mem_w      = 1'b1;
        mem_wAddr  = a_nx;
        mem_byteEn = m_q[7:4];
        mem_in     = s64[63:32];
        state_nx   = RESP;
      end
      LD0: begin
        mem_r      = 1'b1;
        mem_rAddr  = a_q;
        mem_byteEn = 4'hF;
        state_nx   = LD1;
      end
      LD1: begin
        if (cross_q) begin
          mem_r      = 1'b1;
          mem_rAddr  = a_nx;
          mem_byteEn = 4'hF;
          state_nx   = LD2;
        end else begin
          state_nx   = RESP;
        end
      end
      LD2: state_nx = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = (err_q || we_q) ? 32'b0 : ext;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign mem_en = mem_r | mem_w;

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store sequencer between the microcoded core's memory micro-ops and the synchronous byte-enabled data SRAM (registered read, 1-cycle latency, per-byte write enables).
- Converts a byte-addressed RV32 load/store (LB/LH/LW/LBU/LHU/SB/SH/SW) into one or two word accesses.
- Generates byte enables and shifted store data, merges and extends load data, and returns a one-cycle response.
- Misaligned accesses that cross a word boundary are split into two sequential word accesses.

Parameters:
- MEM_SIZE, 1024, SRAM depth in 32-bit words (power of 2).
- MISALIGN_SPLIT, 1, 1 = split word-crossing accesses; 0 = reject them with rsp_err.
- WADDR_WIDTH, $clog2(MEM_SIZE), SRAM word-address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  request present
- req_ready  out  1  controller idle, can accept
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data (0 for stores and errors)
- rsp_err  out  1  illegal funct3 or rejected misalign
- mem_en  out  1  SRAM enable, = mem_r | mem_w
- mem_r  out  1  SRAM read strobe
- mem_w  out  1  SRAM write strobe
- mem_rAddr  out  WADDR_WIDTH  SRAM read word address
- mem_wAddr  out  WADDR_WIDTH  SRAM write word address
- mem_byteEn  out  4  SRAM byte enables
- mem_in  out  32  SRAM write data
- mem_out  in  32  SRAM registered read data

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. Reset forces state IDLE and clears every output to 0 except req_ready, which is 1.
- Reset mid-operation aborts the access. If the first half of a split store has already been written, it stays written. No response is issued.
- Accept: req_ready = 1 only in IDLE. A handshake at cycle T registers we/funct3/addr/wdata.
- Word index A = addr[WADDR_WIDTH+1:2]. Upper address bits are ignored. A+1 wraps modulo MEM_SIZE.
- Size mask: 0001 for B/BU, 0011 for H/HU, 1111 for W.
  - 8-bit mask m = sizemask << addr[1:0].
  - Word-crossing access iff m[7:4] != 0.
- Store data: 64-bit s = {32'b0, wdata} << (8*addr[1:0]).
  - Word A uses byteEn m[3:0] and data s[31:0].
  - Word A+1 uses byteEn m[7:4] and data s[63:32].
- Error: funct3 in {011, 110, 111}, a store with funct3 100/101, or a crossing access with MISALIGN_SPLIT = 0.
  - No SRAM access is made.
  - State goes to RESP with rsp_err = 1 at T+1.
- States: IDLE, ST0, ST1, LD0, LD1, LD2, RESP.
  - IDLE -> ST0 / LD0 / RESP(err) on accept.
  - ST0: mem_w = 1, write word A. Next state is ST1 if crossing, else RESP.
  - ST1: mem_w = 1, write word A+1. Next state is RESP.
  - LD0: mem_r = 1, rAddr = A. Next state is LD1.
  - LD1: capture mem_out into lo. If crossing, mem_r = 1 with rAddr = A+1 and next state is LD2; else next state is RESP.
  - LD2: capture mem_out into hi. Next state is RESP.
  - RESP: rsp_valid = 1 for one cycle, rsp_rdata and rsp_err valid. Next state is IDLE, with req_ready = 1 again in the following cycle.
- Latency from accept at T to rsp_valid:
  - aligned store: T+2
  - split store: T+3
  - aligned load: T+3
  - split load: T+4
  - error: T+1
- Load result: x = ({hi, lo} >> 8*addr[1:0]), truncated to the access size.
  - B and H are sign-extended; BU, HU and W are zero-extended.
  - hi = 0 when the access does not cross a word.
- Outside active states: mem_r, mem_w, mem_en and mem_byteEn are 0.
- No response backpressure: the requester must sample rsp_valid.
- req_valid while busy is ignored; the requester must hold it until accepted.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, accept at T.
  - -> T+1: mem_w = 1, wAddr = 4, byteEn = 1111, mem_in = 0xDEADBEEF.
  - -> T+2: rsp_valid = 1, rsp_err = 0.
- SB addr 0x13 data 0x000000AB -> wAddr = 4, byteEn = 1000, mem_in = 0xAB000000.
  - Then LB 0x13 -> rsp_rdata = 0xFFFFFFAB at T+3.
  - Then LBU 0x13 -> rsp_rdata = 0x000000AB.
- SW addr 0x0E data 0x11223344.
  - -> T+1: wAddr 3, byteEn 1100, mem_in 0x33440000.
  - -> T+2: wAddr 4, byteEn 0011, mem_in 0x00001122.
  - -> rsp at T+3.
  - Then LW 0x0E -> reads of words 3 and 4, rsp_rdata = 0x11223344 at T+4.
- MEM_SIZE = 16, LH addr 0x3F after words 15 = 0xAA000000 and 0 = 0x00000080.
  - -> second read at rAddr 0 (wrap), rsp_rdata = 0xFFFF80AA.
- funct3 = 011 load -> no mem_en, rsp_valid and rsp_err at T+1, rsp_rdata = 0.
  - With MISALIGN_SPLIT = 0, LW 0x02 -> same error response.
- Assert rst in ST1 of a split store -> outputs cleared immediately, req_ready = 1, no rsp_valid, word A already written, word A+1 unchanged.
